xnorpop_stim_gen: RTL and testbench

XNORPOP_STIM_GEN -- requirements
Module: xnorpop_stim_gen

---
 rtl/xnorpop_stim_gen_if.sv | 34 +++
 rtl/xnorpop_stim_gen.sv | 124 ++++++++++++
 tb/tb_xnorpop_stim_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xnorpop_stim_gen_if.sv
// Request/operand handshake bundle for the XNOR-popcount stimulus generator.
// The master side issues targets and consumes operand pairs.
interface xnorpop_stim_gen_if;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   target;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] inx;
  logic [127:0] iny;
  logic [7:0]   expected_sum;

  modport master (
    output req_valid,
    output target,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  inx,
    input  iny,
    input  expected_sum
  );

  modport slave (
    input  req_valid,
    input  target,
    input  out_ready,
    output req_ready,
    output out_valid,
    output inx,
    output iny,
    output expected_sum
  );
endinterface

// File: rtl/xnorpop_stim_gen.sv
// Generates 128-bit operand pairs whose XNOR popcount equals a requested
// target: X from a free-running LFSR, Y = X with a rotated run of matches.
module xnorpop_stim_gen #(
  parameter logic [31:0] LFSR_INIT = 32'hACE10001
) (
  input  logic               clk,
  input  logic               rst,
  xnorpop_stim_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    MASK,
    OUT
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [31:0]  lfsr;
  logic [31:0]  lfsr_n;
  logic [1:0]   widx;
  logic [7:0]   tgt;
  logic [7:0]   tgt_sat;
  logic [127:0] inx_q;
  logic [127:0] iny_q;
  logic [7:0]   sum_q;
  logic [127:0] therm;
  logic [127:0] mask;
  logic [6:0]   rot;
  logic [6:0]   rot_inv;
  logic         req_ready;
  logic         out_valid;

  always_comb begin
    lfsr_n = lfsr >> 1;
    if (lfsr[0]) lfsr_n = (lfsr >> 1) ^ 32'h80200003;
  end

  always_comb begin
    tgt_sat = bus.target;
    if (bus.target > 8'd128) tgt_sat = 8'd128;
  end

  // tgt never exceeds 128, so bit 7 alone marks the all-ones case
  always_comb begin
    therm = '1;
    if (!tgt[7]) therm = (128'd1 << tgt[6:0]) - 128'd1;
    rot     = lfsr[6:0];
    rot_inv = 7'd0 - rot;
    mask    = (therm << rot) | (therm >> rot_inv);
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_n = FILL;
      end
      FILL: begin
        if (widx == 2'd3) state_n = MASK;
      end
      MASK: begin
        state_n = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= LFSR_INIT;
      widx  <= 2'd0;
      tgt   <= 8'd0;
      inx_q <= '0;
      iny_q <= '0;
      sum_q <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            tgt  <= tgt_sat;
            widx <= 2'd0;
          end
        end
        FILL: begin
          lfsr <= lfsr_n;
          widx <= widx + 2'd1;
          inx_q[{widx, 5'd0} +: 32] <= lfsr_n;
        end
        MASK: begin
          iny_q <= inx_q ^ ~mask;
          sum_q <= tgt;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.out_valid    = out_valid;
  assign bus.inx          = inx_q;
  assign bus.iny          = iny_q;
  assign bus.expected_sum = sum_q;

endmodule

// File: tb/tb_xnorpop_stim_gen.sv
// Randomized bench with a behavioural operand-pair model and directed
// checks of reset, saturation, stalls, abort and back-to-back requests.
module tb_xnorpop_stim_gen;

  localparam logic [31:0] INIT = 32'hACE10001;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  xnorpop_stim_gen_if bus ();

  xnorpop_stim_gen #(
    .LFSR_INIT(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    if (v[0]) return (v >> 1) ^ 32'h80200003;
    return v >> 1;
  endfunction

  // Model: cycle position since acceptance and the pair it must yield
  logic [31:0]  m_lfsr;
  int           m_pos;
  logic [127:0] e_inx;
  logic [127:0] e_iny;
  logic [7:0]   e_sum;

  always @(negedge clk) begin
    if (rst) begin
      m_lfsr = INIT;
      m_pos  = 0;
    end else begin
      chk("req_ready", 128'(bus.req_ready), 128'(m_pos == 0));
      chk("out_valid", 128'(bus.out_valid), 128'(m_pos == 6));
      if (m_pos == 6) begin
        chk("inx", bus.inx, e_inx);
        chk("iny", bus.iny, e_iny);
        chk("expected_sum", 128'(bus.expected_sum), 128'(e_sum));
        chk("popcount", 128'($countones(bus.inx ~^ bus.iny)), 128'(e_sum));
      end
      if (m_pos == 0 && bus.req_valid) begin
        int t;
        int r;
        t = (bus.target > 8'd128) ? 128 : int'(bus.target);
        for (int k = 0; k < 4; k++) begin
          m_lfsr = lfsr_step(m_lfsr);
          e_inx[32*k +: 32] = m_lfsr;
        end
        r = int'(m_lfsr[6:0]);
        for (int i = 0; i < 128; i++) begin
          if (((i + 128 - r) % 128) < t) e_iny[i] = e_inx[i];
          else e_iny[i] = ~e_inx[i];
        end
        e_sum = 8'(t);
        m_pos = 1;
      end else if (m_pos >= 1 && m_pos <= 5) begin
        m_pos++;
      end else if (m_pos == 6 && bus.out_ready) begin
        m_pos = 0;
      end
    end
  end

  task automatic do_req(input logic [7:0] t);
    int n;
    bus.req_valid = 1'b1;
    bus.target    = t;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("accept_timeout", 128'(n), 128'(0));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.target    = 8'($urandom);
  endtask

  task automatic wait_done(input int stall_pct);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
    end
    chk("done_timeout", 128'(1), 128'(0));
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 30);
  endtask

  initial begin
    logic [127:0] cap_x;
    logic [127:0] cap_y;
    logic [7:0]   cap_s;
    logic [127:0] first_x;
    int           lat;
    int           gap;
    int           n;

    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.target    = 8'd0;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_inx", bus.inx, 128'(0));
    chk("rst_iny", bus.iny, 128'(0));
    chk("rst_sum", 128'(bus.expected_sum), 128'(0));
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(bus.req_ready), 128'(1));

    do_req(8'd0);
    wait_valid(lat);
    chk("latency", 128'(lat), 128'(5));
    chk("t0_word0", 128'(bus.inx[31:0]), 128'(32'hD6508003));
    chk("t0_iny_inv", bus.iny, ~bus.inx);
    chk("t0_sum", 128'(bus.expected_sum), 128'(0));
    wait_done(0);

    do_req(8'd128);
    wait_valid(lat);
    chk("t128_iny_eq", bus.iny, bus.inx);
    chk("t128_sum", 128'(bus.expected_sum), 128'(128));
    wait_done(0);

    do_req(8'd200);
    wait_valid(lat);
    chk("t200_iny_eq", bus.iny, bus.inx);
    chk("t200_sum", 128'(bus.expected_sum), 128'(128));
    wait_done(0);

    bus.out_ready = 1'b0;
    do_req(8'd37);
    wait_valid(lat);
    cap_x = bus.inx;
    cap_y = bus.iny;
    cap_s = bus.expected_sum;
    chk("t37_sum", 128'(cap_s), 128'(37));
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c == 3);
      bus.target    = 8'd5;
      @(posedge clk);
      #1;
      chk("stall_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_inx", bus.inx, cap_x);
      chk("stall_iny", bus.iny, cap_y);
      chk("stall_sum", 128'(bus.expected_sum), 128'(cap_s));
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_valid", 128'(bus.out_valid), 128'(0));
    chk("idle_ready", 128'(bus.req_ready), 128'(1));
    chk("idle_hold_inx", bus.inx, cap_x);
    chk("idle_hold_iny", bus.iny, cap_y);

    do_req(8'd50);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_inx", bus.inx, 128'(0));
    chk("abort_iny", bus.iny, 128'(0));
    chk("abort_sum", 128'(bus.expected_sum), 128'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    do_req(8'd0);
    wait_valid(lat);
    chk("abort_latency", 128'(lat), 128'(5));
    chk("abort_word0", 128'(bus.inx[31:0]), 128'(32'hD6508003));
    wait_done(0);

    bus.req_valid = 1'b1;
    bus.target    = 8'd10;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    gap = 0;
    first_x = '0;
    @(negedge clk);
    while (!bus.req_ready && gap < 30) begin
      if (bus.out_valid) first_x = bus.inx;
      gap++;
      @(negedge clk);
    end
    chk("busy_gap", 128'(gap), 128'(6));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (bus.inx == first_x) begin
      failures++;
      $display("FAIL b2b_repeat actual=%h differs_from=%h", bus.inx, first_x);
    end
    wait_done(0);

    for (int i = 0; i < 1000; i++) begin
      do_req(8'($urandom_range(0, 128)));
      wait_done(25);
    end
    for (int i = 0; i < 20; i++) begin
      do_req(8'($urandom_range(129, 255)));
      wait_done(25);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
